// File: rtl/nibble_cmp_seq.sv
// rtl/nibble_cmp_seq.sv - sequential nibble-by-nibble equality compare of two operands
//
// comparator_4bit : combinational 4-bit equality
//   x, y : nibbles to compare
//   eq   : 1 when x == y
//
// nibble_cmp_seq  : compares a and b one nibble per cycle, LSB nibble first
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   start    : request a comparison (sampled only in IDLE)
//   a, b     : operands, 4*NIBBLES bits, captured at start acceptance
//   busy     : high while nibbles are being compared
//   done     : one-cycle result strobe
//   equal    : result of the last completed comparison
//   miss_idx : first mismatching nibble index, 0 when equal

module comparator_4bit (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic       eq
);
    assign eq = (x == y);
endmodule

module nibble_cmp_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic                   equal,
    output logic [2:0]             miss_idx
);
    localparam int W = 4 * NIBBLES;
    localparam logic [2:0] LAST = 3'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state, state_nx;
    logic [W-1:0] a_q, b_q, a_nx, b_nx;
    logic [2:0]   cnt, cnt_nx;
    logic         equal_nx;
    logic [2:0]   miss_nx;
    logic [3:0]   nib_a, nib_b;
    logic         nib_eq;

    // Nibble select with constant part-selects so the index never
    // outgrows the operand width for any legal NIBBLES.
    always_comb begin
        nib_a = 4'h0;
        nib_b = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == 3'(i)) begin
                nib_a = a_q[i*4 +: 4];
                nib_b = b_q[i*4 +: 4];
            end
        end
    end

    comparator_4bit u_cmp (
        .x  (nib_a),
        .y  (nib_b),
        .eq (nib_eq)
    );

    always_comb begin
        state_nx = state;
        a_nx     = a_q;
        b_nx     = b_q;
        cnt_nx   = cnt;
        equal_nx = equal;
        miss_nx  = miss_idx;
        unique case (state)
            IDLE: begin
                if (start) begin
                    a_nx     = a;
                    b_nx     = b;
                    cnt_nx   = 3'd0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (!nib_eq) begin
                    equal_nx = 1'b0;
                    miss_nx  = cnt;
                    state_nx = DONE;
                end else if (cnt == LAST) begin
                    equal_nx = 1'b1;
                    miss_nx  = 3'd0;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cnt      <= 3'd0;
            equal    <= 1'b0;
            miss_idx <= 3'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            a_q      <= a_nx;
            b_q      <= b_nx;
            cnt      <= cnt_nx;
            equal    <= equal_nx;
            miss_idx <= miss_nx;
            // Registered flags track the state being entered.
            busy     <= (state_nx == RUN);
            done     <= (state_nx == DONE);
        end
    end
endmodule

// File: tb/tb_nibble_cmp_seq.sv
// tb/tb_nibble_cmp_seq.sv - directed self-checking bench for nibble_cmp_seq

module tb_nibble_cmp_seq;
    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic        equal;
    logic [2:0]  miss_idx;

    int passed;
    int total;

    nibble_cmp_seq #(.NIBBLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .equal    (equal),
        .miss_idx (miss_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Pulse start for one edge, then count negedges until done appears.
    // exp_lat is the negedge index (start-drive negedge = 0) at which done is seen.
    task automatic run_cmp(input string tag, input logic [15:0] av, input logic [15:0] bv,
                           input logic late, input logic [15:0] a_late,
                           input int exp_lat, input logic exp_eq, input logic [2:0] exp_idx);
        int  n;
        int  nb;
        logic seen;
        a = av;
        b = bv;
        start = 1'b1;
        n = 0;
        nb = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start = 1'b0;
                if (late) a = a_late;
            end
            if (done) begin
                seen = 1'b1;
                chk({tag, "_busy_at_done"}, int'(busy), 0);
            end else if (busy) begin
                nb++;
            end
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_busy_cycles"}, nb, exp_lat - 1);
        chk({tag, "_equal"}, int'(equal), int'(exp_eq));
        chk({tag, "_miss_idx"}, int'(miss_idx), int'(exp_idx));
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, int'(done), 0);
    endtask

    initial begin
        int first_done;
        int second_done;
        int ndone;
        int busy_bad;
        passed = 0;
        total  = 0;
        rst   = 1'b1;
        start = 1'b0;
        a = 16'h0;
        b = 16'h0;
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_equal", int'(equal), 0);
        chk("reset_miss", int'(miss_idx), 0);
        rst = 1'b0;
        @(negedge clk);

        run_cmp("full_match", 16'hA5C3, 16'hA5C3, 1'b0, 16'h0, 5, 1'b1, 3'd0);
        run_cmp("miss_nib0", 16'h1234, 16'h1235, 1'b0, 16'h0, 2, 1'b0, 3'd0);
        run_cmp("miss_nib2", 16'h1234, 16'h1034, 1'b0, 16'h0, 4, 1'b0, 3'd2);
        run_cmp("miss_nib3", 16'h1234, 16'h9234, 1'b0, 16'h0, 5, 1'b0, 3'd3);

        // Result registers must hold through start acceptance.
        a = 16'h0F0F;
        b = 16'h0F0F;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'hFFFF;
        chk("hold_equal_at_start", int'(equal), 0);
        chk("hold_miss_at_start", int'(miss_idx), 3);
        repeat (6) @(negedge clk);
        chk("late_change_equal", int'(equal), 1);
        chk("late_change_miss", int'(miss_idx), 0);

        run_cmp("late_change_a", 16'h0F0F, 16'h0F0F, 1'b1, 16'hFFFF, 5, 1'b1, 3'd0);

        // A mismatch result first, so the next equal=1 is a real update.
        run_cmp("pre_held", 16'h0001, 16'h0000, 1'b0, 16'h0, 2, 1'b0, 3'd0);

        // start held high: back-to-back comparisons every NIBBLES+2 cycles.
        a = 16'h7777;
        b = 16'h7777;
        start = 1'b1;
        first_done = -1;
        second_done = -1;
        ndone = 0;
        busy_bad = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (busy) busy_bad++;
                if (first_done < 0) first_done = i;
                else if (second_done < 0) second_done = i;
            end
        end
        start = 1'b0;
        chk("held_first_done", first_done, 5);
        chk("held_period", second_done - first_done, 6);
        chk("held_done_count", ndone, 3);
        chk("held_busy_in_done", busy_bad, 0);
        chk("held_equal", int'(equal), 1);
        repeat (8) @(negedge clk);

        // Asynchronous reset two cycles into RUN.
        a = 16'h4321;
        b = 16'h4321;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_busy_before", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy_async", int'(busy), 0);
        chk("abort_equal_async", int'(equal), 0);
        chk("abort_miss_async", int'(miss_idx), 0);
        chk("abort_done_async", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("abort_no_done", ndone, 0);

        run_cmp("after_reset", 16'hBEEF, 16'hBEEF, 1'b0, 16'h0, 5, 1'b1, 3'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
